// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: sel field encodings, flag bit
// positions and the controller state type.
package alu_pkg;

  // sel[4:3] operation group
  localparam logic [1:0] GRP_BASIC = 2'b00;
  localparam logic [1:0] GRP_SHL   = 2'b01;
  localparam logic [1:0] GRP_SHR   = 2'b10;
  localparam logic [1:0] GRP_ZERO  = 2'b11;

  // sel[1:0] when sel[4:3]=00 and sel[2]=1 (transfer / add)
  localparam logic [1:0] OP_PASS_A = 2'b00;
  localparam logic [1:0] OP_ADDC   = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_PASS_B = 2'b11;

  // sel[1:0] when sel[4:3]=00 and sel[2]=0 (bitwise logic)
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  // flags = {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bus of alu_seq.
// master: drives in_valid, a, b, sel, carry_in, out_ready.
// slave : drives in_ready, out_valid, y, flags.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       sel;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, sel, carry_in, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, a, b, sel, carry_in, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath: transfer, add, logic ops and the
// amount-0 shift / zero cases, together with their {N,Z,C,V} flags.
// Ports: a, b, sel, carry_in in; y_c, flags_c out (combinational).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       sel,
  input  logic             carry_in,
  output logic [WIDTH-1:0] y_c,
  output logic [3:0]       flags_c
);

  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  // Result select; shifts reaching the core have amount 0 and pass A through
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (sel[4:3])
      GRP_BASIC: begin
        if (sel[2]) begin
          case (sel[1:0])
            OP_PASS_A: res = a;
            OP_ADDC: begin
              {carry, res} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(carry_in);
              ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADD: begin
              {carry, res} = (WIDTH+1)'(a) + (WIDTH+1)'(b);
              ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_PASS_B: res = b;
            default:   res = '0;
          endcase
        end else begin
          case (sel[1:0])
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            default: res = '0;
          endcase
        end
      end
      GRP_SHL, GRP_SHR: res = a;
      GRP_ZERO:         res = '0;
      default:          res = '0;
    endcase
  end

  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_N] = res[WIDTH-1];
    flags_c[FLAG_Z] = (res == '0);
    flags_c[FLAG_C] = carry;
    flags_c[FLAG_V] = ovf;
  end

  assign y_c = res;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: ready/valid request in, registered result + flags out.
// Non-shift ops complete in one cycle; shifts of n>0 walk one bit per cycle.
// Ports: clk, rst_n (synchronous, active-low), bus (alu_seq_if.slave).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [3:0]         flags_q, flags_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shl_q, shl_d;
  logic               asr_q, asr_d;

  logic [WIDTH-1:0]   core_y_c;
  logic [3:0]         core_flags_c;
  logic [WIDTH-1:0]   sh_y;
  logic               sh_c;
  logic [3:0]         sh_flags;
  logic               in_ready_c;
  logic               load;
  logic               is_shift;
  logic [SHAMT_W-1:0] amt;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (bus.a),
    .b        (bus.b),
    .sel      (bus.sel),
    .carry_in (bus.carry_in),
    .y_c      (core_y_c),
    .flags_c  (core_flags_c)
  );

  assign is_shift = (bus.sel[4:3] == GRP_SHL) || (bus.sel[4:3] == GRP_SHR);
  assign amt      = bus.b[SHAMT_W-1:0];

  // One-bit shift step; sh_c is the bit falling off the end
  always_comb begin
    if (shl_q) {sh_c, sh_y} = {y_q, 1'b0};
    else       {sh_y, sh_c} = {asr_q & y_q[WIDTH-1], y_q};
    sh_flags         = '0;
    sh_flags[FLAG_N] = sh_y[WIDTH-1];
    sh_flags[FLAG_Z] = (sh_y == '0);
    sh_flags[FLAG_C] = sh_c;
  end

  // Next state, handshake and datapath register updates
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    shl_d      = shl_q;
    asr_d      = asr_q;
    in_ready_c = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        load       = bus.in_valid;
      end
      ST_SHIFT: begin
        y_d     = sh_y;
        flags_d = sh_flags;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Consumer handshake frees the slot in the same cycle
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) load    = 1'b1;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (is_shift && (amt != '0)) begin
        y_d     = bus.a;
        flags_d = '0;
        cnt_d   = amt;
        shl_d   = (bus.sel[4:3] == GRP_SHL);
        asr_d   = bus.sel[2];
        state_d = ST_SHIFT;
      end else begin
        y_d     = core_y_c;
        flags_d = core_flags_c;
        state_d = ST_HOLD;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      asr_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      asr_q   <= asr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.y         = y_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed operations with
// hand-computed results plus a cycle-level reference model checked every cycle.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of each operation: {y, N,Z,C,V}
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] sel, input logic cin);
    logic [7:0] y;
    logic       c, v;
    int         n, s, ss;
    y = 8'h00; c = 1'b0; v = 1'b0;
    n = int'(b) % 8;
    case (sel[4:3])
      2'b00: begin
        if (sel[2]) begin
          case (sel[1:0])
            2'b00: y = a;
            2'b01, 2'b10: begin
              s  = int'(a) + int'(b) + ((sel[1:0] == 2'b01) ? int'(cin) : 0);
              ss = int'($signed(a)) + int'($signed(b)) + ((sel[1:0] == 2'b01) ? int'(cin) : 0);
              y  = s[7:0];
              c  = (s > 255);
              v  = (ss > 127) || (ss < -128);
            end
            default: y = b;
          endcase
        end else begin
          case (sel[1:0])
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~a;
          endcase
        end
      end
      2'b01: begin
        y = 8'(a << n);
        c = (n > 0) ? a[8-n] : 1'b0;
      end
      2'b10: begin
        y = sel[2] ? 8'($signed(a) >>> n) : 8'(a >> n);
        c = (n > 0) ? a[n-1] : 1'b0;
      end
      default: y = 8'h00;
    endcase
    return {y, y[7], (y == 8'h00), c, v};
  endfunction

  function automatic int model_lat(input logic [7:0] b, input logic [4:0] sel);
    int n;
    n = int'(b) % 8;
    if ((sel[4:3] == 2'b01 || sel[4:3] == 2'b10) && n > 0) return n + 1;
    return 1;
  endfunction

  // Cycle-level model: one pending result, visible from a known cycle on
  bit         m_pend = 1'b0;
  bit         m_zero = 1'b0;
  int         m_ready_at = 0;
  logic [7:0] m_y;
  logic [3:0] m_fl;

  initial begin
    logic [11:0] r;
    bit exp_ov, exp_ir;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 1'b0;
        m_zero = 1'b1;
      end else begin
        exp_ov = m_pend && (cyc >= m_ready_at);
        exp_ir = !m_pend || (exp_ov && bus.out_ready);
        chk("m_out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("m_in_ready", 32'(bus.in_ready), 32'(exp_ir));
        if (exp_ov) begin
          chk("m_y", 32'(bus.y), 32'(m_y));
          chk("m_flags", 32'(bus.flags), 32'(m_fl));
        end
        if (m_zero) begin
          chk("m_rst_y", 32'(bus.y), 32'h0);
          chk("m_rst_flags", 32'(bus.flags), 32'h0);
          m_zero = 1'b0;
        end
        if (exp_ov && bus.out_ready) m_pend = 1'b0;
        if (bus.in_valid && exp_ir) begin
          r          = model(bus.a, bus.b, bus.sel, bus.carry_in);
          m_y        = r[11:4];
          m_fl       = r[3:0];
          m_pend     = 1'b1;
          m_ready_at = cyc + model_lat(bus.b, bus.sel);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] sel, input logic cin);
    bus.a        = a;
    bus.b        = b;
    bus.sel      = sel;
    bus.carry_in = cin;
    bus.in_valid = 1'b1;
  endtask

  // Issue one op with out_ready=1 and check result, latency and busy cycles
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] sel, input logic cin,
                       input logic [7:0] exp_y, input logic [3:0] exp_fl,
                       input int exp_lat, input int exp_low);
    int t, low;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(a, b, sel, cin);
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t = 1; low = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 40) begin
      if (!bus.in_ready) low++;
      @(negedge clk);
      t++;
    end
    chk({name, "_lat"}, 32'(t), 32'(exp_lat));
    chk({name, "_y"}, 32'(bus.y), 32'(exp_y));
    chk({name, "_flags"}, 32'(bus.flags), 32'(exp_fl));
    chk({name, "_busy"}, 32'(low), 32'(exp_low));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sel       = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);

    // name, a, b, sel, cin, y, {N,Z,C,V}, latency, in_ready-low cycles
    do_op("addc",     8'hFF, 8'h01, 5'b00101, 1'b1, 8'h01, 4'b0010, 1, 0);
    do_op("add_ovf",  8'h7F, 8'h01, 5'b00110, 1'b0, 8'h80, 4'b1001, 1, 0);
    do_op("shl3",     8'h81, 8'h03, 5'b01000, 1'b0, 8'h08, 4'b0000, 4, 3);
    do_op("asr2",     8'h90, 8'h02, 5'b10100, 1'b0, 8'hE4, 4'b1000, 3, 2);
    do_op("lsr2",     8'h90, 8'h02, 5'b10000, 1'b0, 8'h24, 4'b0000, 3, 2);
    do_op("xor_z",    8'h5A, 8'h5A, 5'b00010, 1'b0, 8'h00, 4'b0100, 1, 0);
    do_op("not",      8'h0F, 8'h00, 5'b00011, 1'b0, 8'hF0, 4'b1000, 1, 0);
    do_op("pass_b",   8'h11, 8'h33, 5'b00111, 1'b1, 8'h33, 4'b0000, 1, 0);
    do_op("zero",     8'hAA, 8'h55, 5'b11101, 1'b1, 8'h00, 4'b0100, 1, 0);
    do_op("shl_amt0", 8'hC3, 8'h08, 5'b01000, 1'b0, 8'hC3, 4'b1000, 1, 0);
    do_op("shl_hi_b", 8'h01, 8'hF9, 5'b01000, 1'b0, 8'h02, 4'b0000, 2, 1);
    do_op("shl_c",    8'hC0, 8'h02, 5'b01000, 1'b0, 8'h00, 4'b0110, 3, 2);
    do_op("asr7",     8'h80, 8'h07, 5'b10100, 1'b0, 8'hFF, 4'b1000, 8, 7);

    // Result held while the consumer stalls; a waiting request is not taken
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(8'h12, 8'h34, 5'b00110, 1'b0);
    @(posedge clk); #1;
    drive(8'hF0, 8'h3C, 5'b00000, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'h1);
      chk("hold_y", 32'(bus.y), 32'h46);
      chk("hold_flags", 32'(bus.flags), 32'h0);
      chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
    end

    // Back-to-back: one result per cycle with both handshakes together
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    drive(8'hF0, 8'h0F, 5'b00001, 1'b0);
    @(negedge clk);
    chk("b2b1_valid", 32'(bus.out_valid), 32'h1);
    chk("b2b1_y", 32'(bus.y), 32'h30);
    @(posedge clk); #1;
    drive(8'h01, 8'hFF, 5'b00110, 1'b0);
    @(negedge clk);
    chk("b2b2_valid", 32'(bus.out_valid), 32'h1);
    chk("b2b2_y", 32'(bus.y), 32'hFF);
    chk("b2b2_flags", 32'(bus.flags), 32'h8);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b3_valid", 32'(bus.out_valid), 32'h1);
    chk("b2b3_y", 32'(bus.y), 32'h00);
    chk("b2b3_flags", 32'(bus.flags), 32'h6);
    @(negedge clk);
    chk("b2b_idle", 32'(bus.out_valid), 32'h0);

    // Reset two steps into a shift of 5 discards the partial result
    @(posedge clk); #1;
    drive(8'h01, 8'h05, 5'b01000, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_y", 32'(bus.y), 32'h0);
    chk("abort_flags", 32'(bus.flags), 32'h0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_result", 32'(bus.out_valid), 32'h0);
    end

    do_op("post_rst", 8'h0A, 8'h05, 5'b00110, 1'b0, 8'h0F, 4'b0000, 1, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
